// File: rtl/kuznechik_decoder.sv
// Iterative Kuznyechik (GOST R 34.12-2015) block decryptor: on-chip key expansion,
// one R / R^-1 step per clock, full-width S / S^-1 layer.
`timescale 1ns/1ps
module kuznechik_decoder (
    input  logic         clk,
    input  logic         rst,
    input  logic         read_key,
    input  logic         read_word,
    input  logic [255:0] input_key,
    input  logic [127:0] input_word,
    output logic [127:0] output_word,
    output logic         write,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, KEYGEN, DECRYPT, DONE} state_t;

    localparam logic [7:0] PI [0:255] = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // Coefficient of byte a_k (k = 0 is the least significant byte) in l().
    localparam logic [7:0] LCOEF [0:15] = '{
        8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
        8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'd0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'hC3) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] lin(input logic [127:0] v);
        logic [7:0] acc;
        acc = 8'd0;
        for (int k = 0; k < 16; k++)
            acc = acc ^ gf_mul(v[8*k +: 8], LCOEF[k]);
        return acc;
    endfunction

    function automatic logic [127:0] r_fwd(input logic [127:0] v);
        return {lin(v), v[127:8]};
    endfunction

    function automatic logic [127:0] r_inv(input logic [127:0] v);
        return {v[119:0], lin({v[119:0], v[127:120]})};
    endfunction

    function automatic logic [127:0] s_fwd(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = PI[v[8*i +: 8]];
        return r;
    endfunction

    // Inverse table is derived from PI so the two can never disagree.
    function automatic logic [7:0] pi_inv(input logic [7:0] b);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 256; i++)
            if (PI[i] == b) r = 8'(i);
        return r;
    endfunction

    function automatic logic [127:0] s_inv(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = pi_inv(v[8*i +: 8]);
        return r;
    endfunction

    state_t         state;
    state_t         state_next;
    logic           read_key_d;
    logic           keys_valid;
    logic [4:0]     cnt;
    logic [5:0]     step;
    logic [3:0]     rnd;
    logic           key_edge;
    logic           capture;
    logic           accept;
    logic           cnt_wrap;
    logic           kg_last;
    logic           dec_last;

    logic [127:0]   ka;
    logic [127:0]   kb;
    logic [127:0]   t;
    logic [127:0]   c;
    logic [127:0]   x;
    logic [127:0]   rk [1:10];

    assign key_edge = read_key && !read_key_d;
    assign cnt_wrap = (cnt == 5'd16);
    assign kg_last  = cnt_wrap && (step == 6'd32);
    assign dec_last = cnt_wrap && (rnd == 4'd1);
    assign ready    = (state == IDLE) && keys_valid;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (key_edge) begin
                    capture    = 1'b1;
                    state_next = KEYGEN;
                end else if (keys_valid && read_word) begin
                    accept     = 1'b1;
                    state_next = DECRYPT;
                end
            end
            KEYGEN:  if (kg_last)  state_next = IDLE;
            DECRYPT: if (dec_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            read_key_d  <= 1'b0;
            keys_valid  <= 1'b0;
            write       <= 1'b0;
            output_word <= '0;
            cnt         <= 5'd0;
            step        <= 6'd0;
            rnd         <= 4'd0;
        end else begin
            state      <= state_next;
            read_key_d <= read_key;
            write      <= (state == DONE);
            if (state == DONE) output_word <= x;

            if (capture)      keys_valid <= 1'b0;
            else if (kg_last) keys_valid <= 1'b1;

            if (capture || accept)
                cnt <= 5'd0;
            else if (state == KEYGEN || state == DECRYPT)
                cnt <= cnt_wrap ? 5'd0 : cnt + 5'd1;

            if (capture)                       step <= 6'd0;
            else if (state == KEYGEN && cnt_wrap) step <= step + 6'd1;

            if (accept)                         rnd <= 4'd9;
            else if (state == DECRYPT && cnt_wrap) rnd <= rnd - 4'd1;
        end
    end

    // Key schedule: each 17-cycle slot runs 16 R steps on both the Feistel term t and
    // the next constant c, then one update cycle applies F and seeds the next slot.
    always_ff @(posedge clk) begin
        if (capture) begin
            ka    <= input_key[255:128];
            kb    <= input_key[127:0];
            rk[1] <= input_key[255:128];
            rk[2] <= input_key[127:0];
            c     <= 128'd1;
        end else if (state == KEYGEN) begin
            if (!cnt_wrap) begin
                c <= r_fwd(c);
                t <= r_fwd(t);
            end else begin
                c <= {122'd0, step} + 128'd2;
                if (step == 6'd0) begin
                    t <= s_fwd(ka ^ c);
                end else begin
                    ka <= t ^ kb;
                    kb <= ka;
                    t  <= s_fwd(t ^ kb ^ c);
                    for (int k = 1; k <= 4; k++) begin
                        if (step == 6'(8 * k)) begin
                            rk[2*k+1] <= t ^ kb;
                            rk[2*k+2] <= ka;
                        end
                    end
                end
            end
        end

        // Decryption rounds: 16 R^-1 steps, then S^-1 and the round key.
        if (accept)
            x <= input_word ^ rk[10];
        else if (state == DECRYPT)
            x <= cnt_wrap ? (s_inv(x) ^ rk[rnd]) : r_inv(x);
    end

endmodule

// File: tb/tb_kuznechik_decoder.sv
// Directed bench for kuznechik_decoder: scoreboard of expected plaintexts and write cycles.
`timescale 1ns/1ps
module tb_kuznechik_decoder;

    localparam logic [255:0] STD_KEY =
        256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         read_key = 1'b0;
    logic         read_word = 1'b0;
    logic [255:0] input_key = '0;
    logic [127:0] input_word = '0;
    logic [127:0] output_word;
    logic         write;
    logic         ready;

    kuznechik_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .read_key    (read_key),
        .read_word   (read_word),
        .input_key   (input_key),
        .input_word  (input_word),
        .output_word (output_word),
        .write       (write),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           at;
        bit           match;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (write === 1'b1) begin
            n_cmp++;
            assert ((sb.size() > 0) === 1'b1) else begin
                n_bad++;
                $error("FAIL unexpected_write: observed write=1 at cycle %0d required no write", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.match) check("plaintext", output_word, e.data);
                else         check("plaintext_differs", 128'(output_word !== e.data), 128'd1);
                check("write_cycle", 128'(cyc), 128'(e.at));
            end
        end
    end

    task automatic wait_ready(input string tag, input int budget, output int waited);
        waited = 0;
        while (ready !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 128'(ready), 128'd1);
    endtask

    task automatic load_key(input logic [255:0] key, input int hold);
        int w;
        int low;
        @(negedge clk);
        read_key  = 1'b0;
        input_key = key;
        @(negedge clk);
        read_key = 1'b1;
        @(negedge clk);
        input_key = ~key;
        check("key_ready_drop", 128'(ready), 128'd0);
        wait_ready("key_ready", 650, w);
        check("key_latency_le_600", 128'((w + 1) <= 600), 128'd1);
        low = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ready !== 1'b1) low++;
        end
        check("key_single_expansion", 128'(low), 128'd0);
        read_key = 1'b0;
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp_v, input bit match);
        @(negedge clk);
        check("dec_ready", 128'(ready), 128'd1);
        input_word = ct;
        read_word  = 1'b1;
        sb.push_back('{exp_v, cyc + 155, match});
        @(negedge clk);
        read_word  = 1'b0;
        input_word = {$urandom, $urandom, $urandom, $urandom};
        check("dec_busy", 128'(ready), 128'd0);
    endtask

    task automatic drain(input int budget);
        int w;
        w = 0;
        while (sb.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin : stim
        int m;
        // Reset with arbitrary inputs applied
        rst        = 1'b1;
        read_key   = 1'b1;
        read_word  = 1'b1;
        input_key  = {STD_KEY[127:0], STD_KEY[255:128]};
        input_word = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        check("rst_output_word", output_word, 128'd0);
        check("rst_write", 128'(write), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        read_key = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("nokey_ready", 128'(ready), 128'd0);
        check("nokey_output_word", output_word, 128'd0);
        drain(0);
        read_word = 1'b0;

        // Key expansion with read_key held high
        load_key(STD_KEY, 700);

        // Single decryption
        decrypt(CT, PT, 1'b1);
        drain(300);
        repeat (20) @(negedge clk);
        check("output_hold", output_word, PT);
        check("ready_after_done", 128'(ready), 128'd1);

        // Continuous decryption for 5000 ns
        @(negedge clk);
        input_word = CT;
        read_word  = 1'b1;
        m = cyc;
        for (int k = 0; k < 4; k++) sb.push_back('{PT, m + 155 + 155 * k, 1'b1});
        repeat (500) @(negedge clk);
        read_word = 1'b0;
        drain(400);

        // Reset 50 cycles after acceptance
        @(negedge clk);
        input_word = CT;
        read_word  = 1'b1;
        @(negedge clk);
        read_word = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ready", 128'(ready), 128'd0);
        check("midrst_write", 128'(write), 128'd0);
        check("midrst_output_word", output_word, 128'd0);
        rst       = 1'b0;
        read_word = 1'b1;
        repeat (200) @(negedge clk);
        read_word = 1'b0;
        check("midrst_ready_after", 128'(ready), 128'd0);
        drain(0);
        load_key(STD_KEY, 0);
        decrypt(CT, PT, 1'b1);
        drain(300);

        // Key change
        load_key(256'd0, 0);
        decrypt(CT, PT, 1'b0);
        drain(300);
        load_key(STD_KEY, 0);
        decrypt(CT, PT, 1'b1);
        // A key edge during decryption must be ignored
        input_key = 256'd0;
        read_key  = 1'b1;
        repeat (3) @(negedge clk);
        read_key = 1'b0;
        drain(300);
        repeat (5) @(negedge clk);
        check("key_edge_ignored_ready", 128'(ready), 128'd1);
        decrypt(CT, PT, 1'b1);
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
